pwm_csr_shadow: RTL and testbench

- Avalon-MM slave register front end that sits directly upstream of the PWM counter/comparator stage. It drives that stage's `period` and `comparison_value` inputs.
- Software writes go into pending (shadow) registers. They are committed only at a PWM period boundary, so the output waveform never glitches mid-period.
- An optional per-period duty ramp slews `comparison_value` toward the target.
- A settle interrupt is raised when the duty reaches its target.

---
 rtl/pwm_csr_shadow.sv | 169 ++++++++++++++++
 tb/tb_pwm_csr_shadow.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_csr_shadow.sv
// pwm_csr_shadow: Avalon-MM register front end for the PWM counter/comparator.
// Software writes land in shadow registers. They are committed to the active
// period/target/step only at a period boundary, so the waveform never glitches
// mid-period. An optional per-period ramp slews the compare value toward the
// target. A settle interrupt flags the moment the duty reaches its target.
module pwm_csr_shadow #(
  parameter logic [15:0] RESET_PERIOD = 16'hFFFF,
  parameter logic [15:0] RESET_STEP   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [15:0] period,
  output logic [15:0] comparison_value,
  output logic        irq
);

  typedef enum logic [1:0] {
    ADDR_CTRL    = 2'd0,
    ADDR_PERIOD  = 2'd1,
    ADDR_COMPARE = 2'd2,
    ADDR_STATUS  = 2'd3
  } addr_e;

  logic        ctrl_en, ctrl_ramp_en, ctrl_irq_en;
  logic [15:0] pend_period, pend_target, pend_step;
  logic        pending, settled;
  logic [15:0] target_active, step_active, cur, phase;

  logic        wr_ctrl, wr_period, wr_compare, wr_status;
  logic        boundary, commit, settle_event;
  logic        en_next, irq_en_next, settled_next;
  logic [15:0] tgt_sel, step_sel, cur_next;
  logic [16:0] up_sum, down_diff;
  logic [31:0] read_mux;

  assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign wr_period  = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_compare = avs_write && (avs_address == ADDR_COMPARE);
  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);

  // The boundary is the cycle in which the downstream counter wraps.
  assign boundary = (phase == period);
  assign commit   = boundary && pending;

  // The duty update sees the freshly committed target/step in a commit cycle.
  assign tgt_sel  = commit ? pend_target : target_active;
  assign step_sel = commit ? pend_step   : step_active;

  // Next duty value: jump, or slew with 17-bit arithmetic clamped at the target.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    up_sum    = {1'b0, cur} + {1'b0, step_sel};
    down_diff = {1'b0, cur} - {1'b0, step_sel};
    cur_next  = cur;
    if (boundary) begin
      if (!ctrl_ramp_en || (step_sel == 16'd0)) begin
        cur_next = tgt_sel;
      end else if (cur < tgt_sel) begin
        cur_next = (up_sum >= {1'b0, tgt_sel}) ? tgt_sel : up_sum[15:0];
      end else if (cur > tgt_sel) begin
        cur_next = (down_diff[16] || (down_diff[15:0] <= tgt_sel)) ? tgt_sel
                                                                   : down_diff[15:0];
      end
    end
  end

  // Settle when the duty lands on target after a commit or after a real move.
  assign settle_event = boundary && (cur_next == tgt_sel) &&
                        (commit || (cur != target_active));

  // A settle event in the same cycle as a write-1-clear keeps SETTLED set.
  assign settled_next = settle_event ? 1'b1 :
                        (wr_status && avs_writedata[2]) ? 1'b0 : settled;

  assign en_next     = wr_ctrl ? avs_writedata[0] : ctrl_en;
  assign irq_en_next = wr_ctrl ? avs_writedata[2] : ctrl_irq_en;

  // Register read multiplexer.
  always_comb begin
    read_mux = 32'd0;
    case (addr_e'(avs_address))
      ADDR_CTRL:    read_mux = {29'd0, ctrl_irq_en, ctrl_ramp_en, ctrl_en};
      ADDR_PERIOD:  read_mux = {16'd0, pend_period};
      ADDR_COMPARE: read_mux = {pend_step, pend_target};
      ADDR_STATUS:  read_mux = {cur, 13'd0, settled, (cur != target_active), pending};
      default:      read_mux = 32'd0;
    endcase
  end

  // Phase mirror of the downstream counter; free-running regardless of EN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      phase <= boundary ? 16'd0 : phase + 16'd1;
    end
  end

  // Control, shadow, commit and duty state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_en       <= 1'b0;
      ctrl_ramp_en  <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      pend_period   <= RESET_PERIOD;
      pend_target   <= 16'd0;
      pend_step     <= RESET_STEP;
      pending       <= 1'b0;
      settled       <= 1'b0;
      period        <= RESET_PERIOD;
      target_active <= 16'd0;
      step_active   <= RESET_STEP;
      cur           <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= avs_writedata[0];
        ctrl_ramp_en <= avs_writedata[1];
        ctrl_irq_en  <= avs_writedata[2];
      end
      if (wr_period) begin
        pend_period <= avs_writedata[15:0];
      end
      if (wr_compare) begin
        pend_target <= avs_writedata[15:0];
        pend_step   <= avs_writedata[31:16];
      end
      if (commit) begin
        period        <= pend_period;
        target_active <= pend_target;
        step_active   <= pend_step;
      end
      // A shadow write in the commit cycle keeps PENDING set for the next boundary.
      if (wr_period || wr_compare) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      cur     <= cur_next;
      settled <= settled_next;
    end
  end

  // Registered outputs to the PWM stage and the interrupt line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      comparison_value <= 16'd0;
      irq              <= 1'b0;
    end else begin
      comparison_value <= en_next ? cur_next : 16'd0;
      irq              <= settled_next && irq_en_next;
    end
  end

  // Read data, latency 1; holds its value when no read is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_pwm_csr_shadow.sv
// tb_pwm_csr_shadow: directed bench for pwm_csr_shadow. Register reads are
// scoreboarded: each read pushes its expected word, and a monitor pops and
// compares when read data becomes valid. PWM-side outputs are checked directly.
module tb_pwm_csr_shadow;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic [15:0] period;
  logic [15:0] comparison_value;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic rd_q;

  pwm_csr_shadow dut (
    .clock            (clk),
    .reset            (rst_n),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .period           (period),
    .comparison_value (comparison_value),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data is valid one cycle after the read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= 1'b0;
    else        rd_q <= avs_read;
  end

  // Monitor: pop and compare whenever read data is presented.
  always @(negedge clk) begin
    if (rd_q) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: read data 0x%08h with no expectation queued", avs_readdata);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, avs_readdata, e.exp);
      end
    end
  end

  // Bus tasks are entered on a falling edge and return on the next one.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
  endtask

  task automatic wait_cv(input logic [15:0] exp, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (comparison_value == exp) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_period(input logic [15:0] exp, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (period == exp) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic read_reset_values(input string tag);
    check({tag, "_period"}, {16'd0, period}, 32'h0000_FFFF);
    check({tag, "_cv"}, {16'd0, comparison_value}, 32'd0);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    bus_read(2'd0, 32'h0000_0000, {tag, "_rd_ctrl"});
    bus_read(2'd1, 32'h0000_FFFF, {tag, "_rd_period"});
    bus_read(2'd2, 32'h0000_0000, {tag, "_rd_compare"});
    bus_read(2'd3, 32'h0000_0000, {tag, "_rd_status"});
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Scenario 1: reset values.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_reset_values("s1");

    // Scenario 2: shadow writes wait for the 0xFFFF boundary.
    bus_write(2'd0, 32'h0000_0001);
    bus_write(2'd1, 32'h0000_0009);
    bus_write(2'd2, 32'h0000_0004);
    bus_read(2'd3, 32'h0000_0001, "s2_pending_set");
    bus_read(2'd1, 32'h0000_0009, "s2_rd_pend_period");
    check("s2_period_held", {16'd0, period}, 32'h0000_FFFF);
    wait_period(16'd9, 70000, "s2_commit_seen");
    check("s2_cv_after_commit", {16'd0, comparison_value}, 32'd4);
    bus_read(2'd3, 32'h0004_0004, "s2_status_after_commit");

    // Scenario 3: ramp up 0 -> 10 in steps of 3, period 9 (10 cycles).
    bus_write(2'd2, 32'h0000_0000);
    wait_cv(16'd0, 20, "s3_back_to_zero");
    bus_write(2'd3, 32'h0000_0004);
    bus_write(2'd0, 32'h0000_0007);
    bus_write(2'd2, 32'h0003_000A);
    wait_cv(16'd3, 20, "s3_step_3");
    bus_read(2'd3, 32'h0003_0002, "s3_status_busy");
    repeat (8) @(negedge clk);
    check("s3_hold_3", {16'd0, comparison_value}, 32'd3);
    @(negedge clk);
    check("s3_step_6", {16'd0, comparison_value}, 32'd6);
    repeat (9) @(negedge clk);
    check("s3_hold_6", {16'd0, comparison_value}, 32'd6);
    @(negedge clk);
    check("s3_step_9", {16'd0, comparison_value}, 32'd9);
    repeat (9) @(negedge clk);
    check("s3_irq_low_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("s3_step_10_clamped", {16'd0, comparison_value}, 32'd10);
    check("s3_irq_high", {31'd0, irq}, 32'd1);
    bus_read(2'd3, 32'h000A_0004, "s3_status_settled");

    // Scenario 4: a shadow write in the commit cycle wins.
    bus_write(2'd1, 32'h0000_0007);
    repeat (7) @(negedge clk);
    bus_write(2'd1, 32'h0000_0005);
    check("s4_period_7", {16'd0, period}, 32'd7);
    bus_read(2'd3, 32'h000A_0005, "s4_pending_kept");
    bus_read(2'd1, 32'h0000_0005, "s4_rd_pend_period");
    repeat (5) @(negedge clk);
    check("s4_period_7_held", {16'd0, period}, 32'd7);
    @(negedge clk);
    check("s4_period_5", {16'd0, period}, 32'd5);
    bus_read(2'd3, 32'h000A_0004, "s4_pending_clear");

    // Scenario 5: ramp down 10 -> 1, step 4, no wrap; then clear SETTLED.
    bus_write(2'd2, 32'h0004_0001);
    bus_write(2'd3, 32'h0000_0004);
    check("s5_irq_cleared", {31'd0, irq}, 32'd0);
    wait_cv(16'd6, 10, "s5_step_6");
    wait_cv(16'd2, 10, "s5_step_2");
    check("s5_irq_low_mid", {31'd0, irq}, 32'd0);
    wait_cv(16'd1, 10, "s5_step_1_clamped");
    check("s5_irq_high", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h0000_0004);
    check("s5_irq_w1c", {31'd0, irq}, 32'd0);
    bus_read(2'd3, 32'h0001_0000, "s5_status_cleared");

    // Scenario 6: disable mid-ramp, then reset mid-ramp.
    bus_write(2'd2, 32'h0001_0010);
    wait_cv(16'd2, 10, "s6_ramp_2");
    bus_write(2'd0, 32'h0000_0006);
    check("s6_cv_gated", {16'd0, comparison_value}, 32'd0);
    bus_read(2'd3, 32'h0002_0002, "s6_status_cur_2");
    repeat (5) @(negedge clk);
    bus_read(2'd3, 32'h0003_0002, "s6_status_cur_3");
    check("s6_cv_still_gated", {16'd0, comparison_value}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_period", {16'd0, period}, 32'h0000_FFFF);
    check("s6_async_cv", {16'd0, comparison_value}, 32'd0);
    check("s6_async_irq", {31'd0, irq}, 32'd0);
    check("s6_async_readdata", avs_readdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_reset_values("s6");

    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
